// File: rtl/elastic_pipe_chain.sv
// elastic_pipe_chain: DEPTH-stage valid/ready register chain with bubble collapse, sync flush, async reset
// Ports: clk, rst_n (async active-low), flush (sync clear), in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream), level (occupied stages, only with PIPE_LEVEL_EN defined)
module elastic_pipe_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level
`endif
);
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic in_fire, out_fire;
  // a stage may advance if any stage from it to the output end is empty, or the sink takes data
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign rdy[i] = out_ready | ~(&v[DEPTH-1:i]);
  end
  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (flush) v <= '0;
    else begin
      if (rdy[0]) begin
        v[0] <= in_fire;
        if (in_fire) d[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++)
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
    end
`ifdef PIPE_LEVEL_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) level <= '0;
    else if (flush) level <= '0;
    else if (in_fire && !out_fire) level <= level + 1'b1;
    else if (out_fire && !in_fire) level <= level - 1'b1;
`endif
endmodule

// File: tb/tb_elastic_pipe_chain.sv
// tb_elastic_pipe_chain: directed and random checks of elastic_pipe_chain against a positional item model
module tb_elastic_pipe_chain;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_LEVEL_EN
  logic [$clog2(DEPTH+1)-1:0] level;
`endif
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [WIDTH-1:0] d; int p;} item_t;
  item_t q[$];
  logic [WIDTH-1:0] outs[$];
  int first_ov;

  elastic_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_LEVEL_EN
    , .level(level)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic iv, logic [WIDTH-1:0] id, logic ordy, logic fl);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
  endtask

  // Model: items oldest-first with their stage position; an item stays put only when the sink
  // stalls and every stage from it to the output end is occupied, otherwise it moves one stage on.
  task automatic cycle();
    bit mv, mir;
    logic [WIDTH-1:0] md;
    int n;
    @(negedge clk);
    mv = 0; md = '0;
    foreach (q[i]) if (q[i].p == DEPTH-1) begin mv = 1; md = q[i].d; end
    mv = mv && !flush;
    mir = (out_ready || q.size() < DEPTH) && !flush;
    chk("in_ready", in_ready, mir);
    chk("out_valid", out_valid, mv);
    if (mv) chk("out_data", out_data, md);
`ifdef PIPE_LEVEL_EN
    chk("level", level, q.size());
`endif
    if (out_valid && out_ready) outs.push_back(out_data);
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (flush) q.delete();
    else begin
      if (out_ready) begin
        if (mv) void'(q.pop_front());
        foreach (q[i]) q[i].p++;
      end else
        foreach (q[i]) begin
          n = 0;
          foreach (q[j]) if (q[j].p >= q[i].p) n++;
          if (n != DEPTH - q[i].p) q[i].p++;
        end
      if (in_valid && mir) q.push_back('{in_data, 0});
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    int s;
    first_ov = -1;
    #12 rst_n = 1;
    @(posedge clk); #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    // async reset mid-operation with 3 items loaded
    for (int k = 0; k < 3; k++) begin drive(1, 8'h30 + k[7:0], 0, 0); cycle(); end
    drive(0, 0, 0, 0);
    rst_n = 0; #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
`ifdef PIPE_LEVEL_EN
    chk("arst_level", level, 0);
`endif
    #1 rst_n = 1;
    q.delete();
    cycle();
    // streaming 0x01..0x10
    outs.delete(); first_ov = -1; s = cyc;
    for (int k = 1; k <= 16; k++) begin drive(1, k[7:0], 1, 0); cycle(); end
    drive(0, 0, 1, 0);
    repeat (6) cycle();
    chk("stream_latency", first_ov - s, 4);
    chk("stream_beats", outs.size(), 16);
    foreach (outs[k]) chk("stream_order", outs[k], k + 1);
    // backpressure 0xA1..0xA5
    outs.delete();
    for (int k = 0; k < 5; k++) begin drive(1, 8'hA1 + k[7:0], 0, 0); cycle(); end
    @(negedge clk);
    chk("bp_full_in_ready", in_ready, 0);
`ifdef PIPE_LEVEL_EN
    chk("bp_level", level, DEPTH);
`endif
    @(posedge clk); #1;
    drive(1, 8'hA5, 1, 0); cycle();
    drive(0, 0, 1, 0);
    repeat (6) cycle();
    chk("bp_beats", outs.size(), 5);
    foreach (outs[k]) chk("bp_order", outs[k], 8'hA1 + k);
    // bubble collapse
    outs.delete();
    drive(1, 8'h11, 0, 0); cycle();
    drive(0, 0, 0, 0); cycle(); cycle();
    drive(1, 8'h22, 0, 0); cycle();
    drive(0, 0, 0, 0); repeat (3) cycle();
    drive(0, 0, 1, 0); repeat (3) cycle();
    chk("bubble_beats", outs.size(), 2);
    chk("bubble_first", outs[0], 8'h11);
    chk("bubble_second", outs[1], 8'h22);
    // simultaneous in/out on a full chain
    for (int k = 0; k < 4; k++) begin drive(1, 8'hB0 + k[7:0], 0, 0); cycle(); end
    drive(1, 8'hB4, 1, 0); cycle();
    drive(0, 0, 0, 0); cycle();
    drive(0, 0, 1, 0); repeat (6) cycle();
    // flush with 3 items held and in_valid high
    for (int k = 0; k < 3; k++) begin drive(1, 8'hC0 + k[7:0], 0, 0); cycle(); end
    drive(1, 8'hCF, 1, 1); cycle();
    outs.delete();
    drive(0, 0, 1, 0); repeat (5) cycle();
    chk("flush_no_emit", outs.size(), 0);
    // random traffic
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      cycle();
    end
    drive(0, 0, 1, 0); repeat (6) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
